// File: rtl/fir_pkg.sv
// Shared types and the output scaling/clipping helper for the band FIR engine.
package fir_pkg;

  typedef enum logic {IDLE = 1'b0, MAC = 1'b1} state_t;

  typedef struct packed {
    logic signed [63:0] val;
    logic               clip;
  } sat_res_t;

  // Works at a fixed 64-bit width so one helper serves every DATA_W/ACC_W choice.
  function automatic sat_res_t sat_shift(input logic signed [63:0] acc,
                                         input int unsigned shift,
                                         input int unsigned dw);
    logic signed [63:0] sh, hi, lo;
    sat_res_t r;
    sh     = acc >>> shift;
    hi     = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo     = -(64'sd1 <<< (dw - 1));
    r.clip = (sh > hi) || (sh < lo);
    r.val  = (sh > hi) ? hi : (sh < lo) ? lo : sh;
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One channel: full-precision multiply, accumulate, then shift/clip into a held output register.
module fir_mac_lane
  import fir_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 16,
  parameter int ACC_W   = 42,
  parameter int SHIFT   = 15
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_en,
  input  logic                      i_cap,
  input  logic signed [DATA_W-1:0]  i_smpl,
  input  logic signed [COEFF_W-1:0] i_coeff,
  output logic [DATA_W-1:0]         o_smpl,
  output logic                      o_sat
);

  logic signed [DATA_W+COEFF_W-1:0] w_prod;
  logic signed [ACC_W-1:0]          r_acc;
  logic [DATA_W-1:0]                r_out;
  logic                             r_sat;
  sat_res_t                         w_res;
  logic                             w_unused;

  assign w_prod   = i_smpl * i_coeff;
  assign w_res    = sat_shift(64'(r_acc), SHIFT, DATA_W);
  assign w_unused = ^w_res.val[63:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_out <= '0;
      r_sat <= 1'b0;
    end else begin
      if (i_clr)     r_acc <= '0;
      else if (i_en) r_acc <= r_acc + ACC_W'(w_prod);
      if (i_cap) begin
        r_out <= w_res.val[DATA_W-1:0];
        r_sat <= w_res.clip;
      end
    end
  end

  assign o_smpl = r_out;
  assign o_sat  = r_sat;

endmodule

// File: rtl/fir_band_mac.sv
// Multi-channel FIR MAC for one equalizer band: burst sequencing, ROM addressing, tap guard.
module fir_band_mac
  import fir_pkg::*;
#(
  parameter  int NUM_TAPS = 1023,
  parameter  int NUM_CH   = 2,
  parameter  int DATA_W   = 16,
  parameter  int COEFF_W  = 16,
  parameter  int SHIFT    = COEFF_W - 1,
  localparam int ADDR_W   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
  localparam int ACC_W    = DATA_W + COEFF_W + ADDR_W
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sequencing,
  input  logic [NUM_CH*DATA_W-1:0] smpl_in,
  output logic [ADDR_W-1:0]        coeff_addr,
  input  logic [COEFF_W-1:0]       coeff_in,
  output logic [NUM_CH*DATA_W-1:0] smpl_out,
  output logic                     vld,
  output logic [NUM_CH-1:0]        sat,
  output logic                     tap_ovr
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_vld;
  logic              r_tap_ovr;
  logic              w_clr, w_en, w_cap;

  assign w_clr = (r_state == IDLE) && sequencing;
  assign w_en  = (r_state == MAC) && sequencing && (r_cnt < CNT_W'(NUM_TAPS));
  assign w_cap = (r_state == MAC) && !sequencing;

  // The ROM answers one clock late, so the address runs one ahead of the MAC
  // cycle: the priming edge already steps it to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_vld     <= 1'b0;
      r_tap_ovr <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        IDLE: if (sequencing) begin
          r_state   <= MAC;
          r_cnt     <= '0;
          r_tap_ovr <= 1'b0;
          r_addr    <= (NUM_TAPS > 1) ? ADDR_W'(1) : '0;
        end
        MAC: if (sequencing) begin
          if (r_cnt < CNT_W'(NUM_TAPS)) r_cnt     <= r_cnt + 1'b1;
          else                          r_tap_ovr <= 1'b1;
          if (r_addr != ADDR_W'(NUM_TAPS - 1)) r_addr <= r_addr + 1'b1;
        end else begin
          r_state <= IDLE;
          r_vld   <= 1'b1;
          r_addr  <= '0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    fir_mac_lane #(
      .DATA_W (DATA_W),
      .COEFF_W(COEFF_W),
      .ACC_W  (ACC_W),
      .SHIFT  (SHIFT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_en   (w_en),
      .i_cap  (w_cap),
      .i_smpl (smpl_in[k*DATA_W +: DATA_W]),
      .i_coeff(coeff_in),
      .o_smpl (smpl_out[k*DATA_W +: DATA_W]),
      .o_sat  (sat[k])
    );
  end

  assign coeff_addr = r_addr;
  assign vld        = r_vld;
  assign tap_ovr    = r_tap_ovr;

endmodule

// File: tb/tb_fir_band_mac.sv
// Bench for fir_band_mac (4 taps, 2 channels) with a behavioural sum-of-products reference.
module tb_fir_band_mac;

  localparam int TAPS = 4;
  localparam int NCH  = 2;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int AW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sequencing = 1'b0;
  logic [NCH*DW-1:0] smpl_in = '0;
  logic [AW-1:0]     coeff_addr;
  logic [CW-1:0]     coeff_in;
  logic [NCH*DW-1:0] smpl_out;
  logic              vld;
  logic [NCH-1:0]    sat;
  logic              tap_ovr;

  logic [CW-1:0]     rom [TAPS];
  logic [DW-1:0]     smp [NCH][16];
  int                obs_addr [20];
  logic              obs_vld  [20];
  logic [NCH*DW-1:0] obs_out0;
  int                n_cmp = 0;
  int                n_err = 0;

  fir_band_mac #(.NUM_TAPS(TAPS), .NUM_CH(NCH), .DATA_W(DW), .COEFF_W(CW)) dut (
    .clk(clk), .rst(rst), .sequencing(sequencing), .smpl_in(smpl_in),
    .coeff_addr(coeff_addr), .coeff_in(coeff_in), .smpl_out(smpl_out),
    .vld(vld), .sat(sat), .tap_ovr(tap_ovr)
  );

  always #5 clk = ~clk;

  // external synchronous coefficient ROM
  always @(posedge clk) coeff_in <= rom[coeff_addr];

  // Reference: sum over the first min(n, TAPS) samples of sample*coef, floor-shift by 15, clip.
  task automatic model(input int n, output logic [NCH*DW-1:0] eo, output logic [NCH-1:0] es);
    longint acc, sh;
    for (int ch = 0; ch < NCH; ch++) begin
      acc = 0;
      for (int k = 0; k < n && k < TAPS; k++)
        acc += longint'($signed(smp[ch][k])) * longint'($signed(rom[k]));
      sh = acc >>> 15;
      es[ch] = (sh > 32767) || (sh < -32768);
      if (sh > 32767)       eo[ch*DW +: DW] = 16'h7FFF;
      else if (sh < -32768) eo[ch*DW +: DW] = 16'h8000;
      else                  eo[ch*DW +: DW] = DW'(sh);
    end
  endtask

  // Priming cycle plus n sample cycles, then sequencing drops; records outputs seen each cycle.
  task automatic drive_burst(input int n);
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      obs_addr[c] = int'(coeff_addr);
      obs_vld[c]  = vld;
      if (c == 0) obs_out0 = smpl_out;
      sequencing = 1'b1;
      for (int ch = 0; ch < NCH; ch++)
        smpl_in[ch*DW +: DW] = (c == 0) ? DW'($urandom) : smp[ch][c-1];
    end
    @(negedge clk);
    sequencing = 1'b0;
    smpl_in    = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (smpl_out !== '0) begin n_err++; $display("FAIL reset_out got %h exp 0", smpl_out); end
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b exp 0", vld); end
    n_cmp++; if (sat !== '0) begin n_err++; $display("FAIL reset_sat got %b exp 0", sat); end
    n_cmp++; if (tap_ovr !== 1'b0) begin n_err++; $display("FAIL reset_tapovr got %b exp 0", tap_ovr); end
    n_cmp++; if (coeff_addr !== '0) begin n_err++; $display("FAIL reset_addr got %0d exp 0", coeff_addr); end
    rst = 1'b0;
  endtask

  task automatic test_unity();
    logic [NCH*DW-1:0] eo; logic [NCH-1:0] es;
    rom[0] = 16'h4000; rom[1] = 16'h4000; rom[2] = CW'($urandom); rom[3] = CW'($urandom);
    smp[0][0] = 16'h4000; smp[0][1] = 16'h4000;
    smp[1][0] = DW'($urandom); smp[1][1] = DW'($urandom);
    model(2, eo, es);
    drive_burst(2);
    n_cmp++; if (obs_vld[1] !== 1'b0 || obs_vld[2] !== 1'b0) begin n_err++; $display("FAIL unity_early_vld got %b%b exp 00", obs_vld[1], obs_vld[2]); end
    @(negedge clk);
    n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL unity_vld got %b exp 1", vld); end
    n_cmp++; if (smpl_out[DW-1:0] !== 16'h4000) begin n_err++; $display("FAIL unity_ch0 got %h exp 4000", smpl_out[DW-1:0]); end
    n_cmp++; if (sat[0] !== 1'b0) begin n_err++; $display("FAIL unity_sat0 got %b exp 0", sat[0]); end
    n_cmp++; if (smpl_out !== eo || sat !== es) begin n_err++; $display("FAIL unity_model got %h/%b exp %h/%b", smpl_out, sat, eo, es); end
    @(negedge clk);
    n_cmp++; if (vld !== 1'b0 || smpl_out !== eo) begin n_err++; $display("FAIL unity_hold got %b/%h exp 0/%h", vld, smpl_out, eo); end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] pat [2];
    pat[0] = 16'h7FFF; pat[1] = 16'h8000;
    for (int k = 0; k < TAPS; k++) rom[k] = 16'h7FFF;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < TAPS; k++) begin smp[0][k] = pat[p]; smp[1][k] = pat[p]; end
      drive_burst(TAPS);
      @(negedge clk);
      n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL sat_vld_%0d got %b exp 1", p, vld); end
      n_cmp++; if (smpl_out !== {pat[p], pat[p]}) begin n_err++; $display("FAIL sat_out_%0d got %h exp %h", p, smpl_out, {pat[p], pat[p]}); end
      n_cmp++; if (sat !== 2'b11) begin n_err++; $display("FAIL sat_flag_%0d got %b exp 11", p, sat); end
    end
  endtask

  task automatic test_mid_reset();
    logic [NCH*DW-1:0] eo; logic [NCH-1:0] es;
    bit seen;
    for (int k = 0; k < TAPS; k++) rom[k] = CW'($urandom);
    for (int k = 0; k < 8; k++) begin smp[0][k] = DW'($urandom); smp[1][k] = DW'($urandom); end
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      sequencing = 1'b1;
      smpl_in = (c == 0) ? $urandom : {smp[1][c-1], smp[0][c-1]};
    end
    @(negedge clk);
    n_cmp++; if (tap_ovr !== 1'b1) begin n_err++; $display("FAIL midrst_pre_tapovr got %b exp 1", tap_ovr); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (smpl_out !== '0 || sat !== '0 || tap_ovr !== 1'b0 || vld !== 1'b0 || coeff_addr !== '0)
      begin n_err++; $display("FAIL midrst_clear got out=%h sat=%b ovr=%b vld=%b addr=%0d exp all 0", smpl_out, sat, tap_ovr, vld, coeff_addr); end
    rst = 1'b0; sequencing = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (vld !== 1'b0) seen = 1'b1; end
    n_cmp++; if (seen) begin n_err++; $display("FAIL midrst_no_vld got vld=1 exp 0"); end
    model(3, eo, es);
    drive_burst(3);
    @(negedge clk);
    n_cmp++; if (vld !== 1'b1 || smpl_out !== eo || sat !== es) begin n_err++; $display("FAIL midrst_after got %b/%h/%b exp 1/%h/%b", vld, smpl_out, sat, eo, es); end
  endtask

  task automatic test_tap_ovr();
    logic [NCH*DW-1:0] eo; logic [NCH-1:0] es;
    int ea;
    for (int k = 0; k < TAPS; k++) rom[k] = CW'($urandom_range(16'h7FFF, 0));
    for (int k = 0; k < 7; k++) begin smp[0][k] = DW'($urandom); smp[1][k] = DW'($urandom); end
    model(7, eo, es);
    drive_burst(7);
    for (int c = 0; c <= 7; c++) begin
      ea = (c < TAPS - 1) ? c : TAPS - 1;
      n_cmp++; if (obs_addr[c] != ea) begin n_err++; $display("FAIL tapovr_addr_c%0d got %0d exp %0d", c, obs_addr[c], ea); end
    end
    @(negedge clk);
    n_cmp++; if (vld !== 1'b1 || smpl_out !== eo || sat !== es) begin n_err++; $display("FAIL tapovr_out got %b/%h/%b exp 1/%h/%b", vld, smpl_out, sat, eo, es); end
    n_cmp++; if (tap_ovr !== 1'b1) begin n_err++; $display("FAIL tapovr_flag got %b exp 1", tap_ovr); end
    // zero-MAC burst: one sequencing cycle only
    drive_burst(0);
    n_cmp++; if (tap_ovr !== 1'b0) begin n_err++; $display("FAIL tapovr_clear got %b exp 0", tap_ovr); end
    @(negedge clk);
    n_cmp++; if (vld !== 1'b1 || smpl_out !== '0 || sat !== '0) begin n_err++; $display("FAIL zero_burst got %b/%h/%b exp 1/0/0", vld, smpl_out, sat); end
  endtask

  task automatic test_back_to_back();
    logic [NCH*DW-1:0] ea, eb; logic [NCH-1:0] sa, sb;
    for (int k = 0; k < TAPS; k++) rom[k] = 16'h7FFF;
    for (int k = 0; k < 3; k++) begin smp[0][k] = 16'sd1000; smp[1][k] = -16'sd1000; end
    model(3, ea, sa);
    drive_burst(3);
    smp[0][0] = 16'sd1000; smp[1][0] = -16'sd1000;
    model(1, eb, sb);
    drive_burst(1);
    n_cmp++; if (obs_vld[0] !== 1'b1 || obs_out0 !== ea) begin n_err++; $display("FAIL b2b_first got %b/%h exp 1/%h", obs_vld[0], obs_out0, ea); end
    n_cmp++; if (obs_out0[DW-1] !== 1'b0 || obs_out0[2*DW-1] !== 1'b1) begin n_err++; $display("FAIL b2b_signs got %h exp ch0>0 ch1<0", obs_out0); end
    n_cmp++; if (obs_vld[1] !== 1'b0) begin n_err++; $display("FAIL b2b_pulse_len got %b exp 0", obs_vld[1]); end
    @(negedge clk);
    n_cmp++; if (vld !== 1'b1 || smpl_out !== eb || sat !== sb) begin n_err++; $display("FAIL b2b_second got %b/%h/%b exp 1/%h/%b", vld, smpl_out, sat, eb, sb); end
  endtask

  task automatic test_random();
    logic [NCH*DW-1:0] eo; logic [NCH-1:0] es;
    int n;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < TAPS; k++) rom[k] = CW'($urandom);
      n = $urandom_range(6, 0);
      for (int k = 0; k < n; k++) begin smp[0][k] = DW'($urandom); smp[1][k] = DW'($urandom); end
      model(n, eo, es);
      drive_burst(n);
      @(negedge clk);
      n_cmp++; if (vld !== 1'b1 || smpl_out !== eo || sat !== es) begin n_err++; $display("FAIL rand_%0d_n%0d got %b/%h/%b exp 1/%h/%b", it, n, vld, smpl_out, sat, eo, es); end
      n_cmp++; if (tap_ovr !== (n > TAPS)) begin n_err++; $display("FAIL rand_%0d_tapovr got %b exp %b", it, tap_ovr, n > TAPS); end
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
  endtask

  initial begin
    for (int k = 0; k < TAPS; k++) rom[k] = '0;
    test_reset();
    test_unity();
    test_saturation();
    test_mid_reset();
    test_tap_ovr();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
